qea_host_sequencer: RTL and testbench
=====================================

// Module: qea_host_sequencer
// PURPOSE
// - Hardware host for the QEA core: streams gate-context words into CTX RAM, initialises STATE RAM to |0...0>,
//   pulses start, waits for completion, then streams the final state vector out on a ready/valid interface.
// - Sits between a DMA/AXI-stream front end and the QEA load, start and readback ports.
// - Replaces bench-driven loading so a full QFT run needs only i_go plus the context stream.
// PARAMETERS
// - PE_NUM 4: PEs per state row.
// - PE_NUM_WIDTH 2: log2(PE_NUM).
// - STATE_DATA_WIDTH 64: complex amplitude per PE, {re[63:32], im[31:0]}.
// - STATE_ADDR_WIDTH 16: STATE RAM row address.
// - GATE_CONTEXT_DATA_WIDTH 64, GATE_CONTEXT_ADDR_WIDTH 16: CTX RAM word and address widths.
// - MAX_QBIT_WIDTH 6: width of the qubit count.
// - NUM_FRAC_BIT 30: fixed-point fraction bits; amplitude 1.0 = 1<<NUM_FRAC_BIT.
// - TIMEOUT_CYCLES 32'd1000000: RUN limit, used only with QEA_RUN_TIMEOUT_EN.
// PORTS
// - clk              in   1          clock
// - rst              in   1          synchronous reset, active-high
// - i_go             in   1          start sequence; sampled only in IDLE
// - i_ins_num        in   CTX_AW     number of context words to load
// - i_qbit_num       in   MAX_QBIT_W qubit count; latched on i_go
// - s_ctx_valid      in   1          context word valid
// - s_ctx_ready      out  1          context word ready
// - s_ctx_data       in   CTX_DW     context word
// - o_qea_start      out  1          one-cycle start pulse to QEA
// - o_qea_qbit_num   out  MAX_QBIT_W latched qubit count
// - o_ctx_en         out  1          CTX RAM enable
// - o_ctx_wea        out  1          CTX RAM write enable
// - o_ctx_addr       out  CTX_AW     CTX RAM address
// - o_ctx_data       out  CTX_DW     CTX RAM write data
// - o_state_ena      out  PE_NUM     STATE RAM per-PE enable
// - o_state_wea      out  PE_NUM     STATE RAM per-PE write enable
// - o_state_addra    out  ST_AW      STATE RAM row address
// - o_state_dina     out  PE_NUM*64  STATE RAM write row
// - i_qea_complete   in   1          QEA done (level)
// - i_qea_state_dout in   PE_NUM*64  STATE RAM read row
// - m_res_valid      out  1          result row valid
// - m_res_ready      in   1          result row ready
// - m_res_data       out  PE_NUM*64  result row
// - m_res_addr       out  ST_AW      row index of m_res_data
// - m_res_last       out  1          final row
// - o_busy           out  1          high in any state except IDLE
// - o_done           out  1          one-cycle pulse on DONE
// - o_error          out  1          sticky timeout flag; cleared on next accepted i_go
// - o_run_cycles     out  32         cycles from start pulse to complete seen
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, o_error cleared. Reset mid-operation aborts at once; partial RAM content is don't-care.
// - FSM: IDLE -> LOAD_CTX -> INIT_ST -> START -> RUN -> READ -> DONE -> IDLE.
// - IDLE: on i_go, latch i_qbit_num and i_ins_num. ROWS = (qbit <= PE_NUM_WIDTH) ? 1 : 2**(qbit-PE_NUM_WIDTH).
//   If i_ins_num==0, go straight to INIT_ST.
// - LOAD_CTX: s_ctx_ready=1.
//   - On each handshake, the same cycle drives o_ctx_en=o_ctx_wea=1, o_ctx_data=s_ctx_data, o_ctx_addr=k (k=0..N-1); registered outputs, 1-cycle latency.
//   - No handshake means en/wea=0 that cycle.
//   - After word N-1, ready drops and the FSM goes to INIT_ST.
// - INIT_ST: one row per cycle for ROWS cycles; ena=wea='1 (all PEs), addra 0..ROWS-1.
//   - Row 0 dina: lane PE_NUM-1 re = 1<<NUM_FRAC_BIT, all other lanes and fields 0. Other rows: 0.
// - START: o_qea_start=1 for exactly one cycle; o_run_cycles cleared.
// - RUN: o_run_cycles increments every cycle.
//   - i_qea_complete is ignored for the 2 cycles after the start pulse (stale level from a previous run); after that, the first high moves to READ.
// - READ: ena='1, wea=0.
//   - Read latency is 1 cycle into a 2-entry output FIFO; a read issues only when occupancy + in-flight < 2.
//   - Sustains 1 row/cycle while m_res_ready=1.
//   - m_res_last=1 with addr ROWS-1. Valid/data/addr stay stable while valid && !ready.
//   - Go to DONE after the last handshake.
// - DONE: o_done=1 for one cycle, then IDLE.
// - i_go outside IDLE is ignored. Address counters never wrap: ROWS <= 2**ST_AW by construction.
// CONFIGURATION
// - QEA_RUN_TIMEOUT_EN defined: if RUN lasts TIMEOUT_CYCLES without complete, set o_error=1, skip READ, go to DONE (o_done still pulses).
// - QEA_RUN_TIMEOUT_EN undefined: RUN waits indefinitely; o_error is tied 0.
// TESTING
// - 12 qubits, 1165 ctx words, valid always high -> 1165 CTX writes at addr 0..1164 in 1165 cycles;
//   1024 INIT writes, row 0 = 64'h40000000_00000000 in the top lane.
// - ctx valid low on every 3rd cycle -> no write in gap cycles; addresses stay contiguous; all 1165 words written.
// - Complete held high from a previous run at the start pulse -> not taken for 2 cycles; RUN exits on the first high after that.
// - Readback with m_res_ready toggling 1/0 -> 1024 rows in order with no loss or duplicates; last asserted only on addr 1023.
// - qbit=2, ins_num=0 -> LOAD_CTX skipped, ROWS=1, one result beat with last=1; rst mid-READ -> all outputs 0 next cycle.
// - With QEA_RUN_TIMEOUT_EN and complete never asserted -> o_error=1 after TIMEOUT_CYCLES, o_done pulses, no m_res_valid.

Source files
------------

// File: rtl/qea_host_sequencer.sv
// -----------------------------------------------------------------------------
// qea_host_sequencer
//
// Hardware host for the QEA core. One i_go runs this sequence:
//   1. stream i_ins_num gate-context words from s_ctx_* into CTX RAM;
//   2. initialise STATE RAM to |0...0>, one row per cycle;
//   3. pulse o_qea_start and wait for i_qea_complete;
//   4. read the final state vector back and stream it out on m_res_*.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_go                start request, sampled only while idle
//   i_ins_num           number of context words to load (latched on i_go)
//   i_qbit_num          qubit count (latched on i_go, shown on o_qea_qbit_num)
//   s_ctx_*             ready/valid context word input
//   o_ctx_*             CTX RAM write port (registered, 1-cycle latency)
//   o_state_*           STATE RAM port A (init writes, then readback reads)
//   i_qea_state_dout    STATE RAM read row, 1-cycle read latency
//   i_qea_complete      QEA done level
//   o_qea_start         one-cycle start pulse to the QEA
//   m_res_*             ready/valid result rows, m_res_last on the final row
//   o_busy, o_done      status: not idle / one-cycle done pulse
//   o_error             sticky run timeout flag
//   o_run_cycles        cycles from start pulse to complete taken
//
// Build option
//   QEA_RUN_TIMEOUT_EN  when defined, RUN gives up after TIMEOUT_CYCLES,
//                       sets o_error, skips readback and goes to DONE.
//                       When undefined RUN waits forever and o_error is 0.
// -----------------------------------------------------------------------------
module qea_host_sequencer #(
    parameter int          PE_NUM                  = 4,
    parameter int          PE_NUM_WIDTH            = 2,
    parameter int          STATE_DATA_WIDTH        = 64,
    parameter int          STATE_ADDR_WIDTH        = 16,
    parameter int          GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int          GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int          MAX_QBIT_WIDTH          = 6,
    parameter int          NUM_FRAC_BIT            = 30,
    parameter logic [31:0] TIMEOUT_CYCLES          = 32'd1000000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_go,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 s_ctx_valid,
    output logic                                 s_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
    output logic                                 m_res_valid,
    input  logic                                 m_res_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_res_data,
    output logic [STATE_ADDR_WIDTH-1:0]          m_res_addr,
    output logic                                 m_res_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_error,
    output logic [31:0]                          o_run_cycles
);

    localparam int ROW_W  = STATE_ADDR_WIDTH + 1;   // row count up to 2**ST_AW
    localparam int ROW_DW = PE_NUM * STATE_DATA_WIDTH;
    localparam int HALF_W = STATE_DATA_WIDTH / 2;
    localparam logic [HALF_W-1:0] AMP_ONE = HALF_W'(1) << NUM_FRAC_BIT;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_CTX = 3'd1;
    localparam logic [2:0] S_INIT_ST  = 3'd2;
    localparam logic [2:0] S_START    = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_READ     = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]                          state_reg;
    logic [MAX_QBIT_WIDTH-1:0]           qbit_reg;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ins_num_reg;
    logic [ROW_W-1:0]                    rows_reg;
    logic [ROW_W-1:0]                    rows_calc;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ctx_cnt_reg;
    logic                                ctx_en_reg;
    logic                                ctx_wea_reg;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ctx_addr_reg;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]  ctx_data_reg;
    logic [ROW_W-1:0]                    row_cnt_reg;   // init row, then next read row
    logic [31:0]                         run_cycles_reg;

    // Readback path: one read in flight stage plus a 2-entry output FIFO.
    logic                                pend_reg;
    logic [STATE_ADDR_WIDTH-1:0]         pend_addr_reg;
    logic [1:0]                          fifo_cnt_reg;
    logic                                fifo_wr_ptr_reg;
    logic                                fifo_rd_ptr_reg;
    logic [ROW_DW-1:0]                   fifo_data_reg [2];
    logic [STATE_ADDR_WIDTH-1:0]         fifo_addr_reg [2];
    logic                                fifo_last_reg [2];

    logic                                ctx_hs;
    logic                                res_pop;
    logic                                rd_issue;
    logic                                run_take;
    logic [1:0]                          occ_after_pop;
    logic [ROW_DW-1:0]                   init_row;

    // |0...0>: amplitude 1.0 in the real half of the top lane of row 0.
    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_init_lane
            if (gi == PE_NUM - 1) begin : g_one
                assign init_row[gi*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = {AMP_ONE, {HALF_W{1'b0}}};
            end else begin : g_zero
                assign init_row[gi*STATE_DATA_WIDTH +: STATE_DATA_WIDTH] = '0;
            end
        end
    endgenerate

    always_comb begin
        if (i_qbit_num <= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) begin
            rows_calc = ROW_W'(1);
        end else begin
            rows_calc = ROW_W'(1) << (i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH));
        end
    end

    assign ctx_hs      = (state_reg == S_LOAD_CTX) && s_ctx_valid;
    assign m_res_valid = (fifo_cnt_reg != 2'd0);
    assign res_pop     = m_res_valid && m_res_ready;

    // Counting the slot freed by this cycle's pop lets reads overlap the
    // 1-cycle RAM latency, so a 2-entry FIFO keeps up at one row per cycle.
    assign occ_after_pop = fifo_cnt_reg - {1'b0, res_pop};
    assign rd_issue = (state_reg == S_READ) && (row_cnt_reg < rows_reg) &&
                      ((occ_after_pop + {1'b0, pend_reg}) < 2'd2);

    // The complete level is ignored during the first two RUN cycles, which
    // is when run_cycles_reg is still 0 or 1.
    assign run_take = (state_reg == S_RUN) && (run_cycles_reg >= 32'd2) && i_qea_complete;

    always_comb begin
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        if (state_reg == S_INIT_ST) begin
            o_state_ena   = '1;
            o_state_wea   = '1;
            o_state_addra = row_cnt_reg[STATE_ADDR_WIDTH-1:0];
            if (row_cnt_reg == '0) begin
                o_state_dina = init_row;
            end
        end else if (rd_issue) begin
            o_state_ena   = '1;
            o_state_addra = row_cnt_reg[STATE_ADDR_WIDTH-1:0];
        end
    end

`ifdef QEA_RUN_TIMEOUT_EN
    logic error_reg;
    assign o_error = error_reg;
`else
    assign o_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            qbit_reg        <= '0;
            ins_num_reg     <= '0;
            rows_reg        <= '0;
            ctx_cnt_reg     <= '0;
            ctx_en_reg      <= 1'b0;
            ctx_wea_reg     <= 1'b0;
            ctx_addr_reg    <= '0;
            ctx_data_reg    <= '0;
            row_cnt_reg     <= '0;
            run_cycles_reg  <= '0;
            pend_reg        <= 1'b0;
            pend_addr_reg   <= '0;
            fifo_cnt_reg    <= '0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
`ifdef QEA_RUN_TIMEOUT_EN
            error_reg       <= 1'b0;
`endif
        end else begin
            ctx_en_reg  <= 1'b0;
            ctx_wea_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_go) begin
                        qbit_reg    <= i_qbit_num;
                        ins_num_reg <= i_ins_num;
                        rows_reg    <= rows_calc;
                        ctx_cnt_reg <= '0;
                        row_cnt_reg <= '0;
`ifdef QEA_RUN_TIMEOUT_EN
                        error_reg   <= 1'b0;
`endif
                        state_reg   <= (i_ins_num == '0) ? S_INIT_ST : S_LOAD_CTX;
                    end
                end
                S_LOAD_CTX: begin
                    if (ctx_hs) begin
                        ctx_en_reg   <= 1'b1;
                        ctx_wea_reg  <= 1'b1;
                        ctx_addr_reg <= ctx_cnt_reg;
                        ctx_data_reg <= s_ctx_data;
                        ctx_cnt_reg  <= ctx_cnt_reg + 1'b1;
                        if (ctx_cnt_reg == ins_num_reg - 1'b1) begin
                            state_reg <= S_INIT_ST;
                        end
                    end
                end
                S_INIT_ST: begin
                    row_cnt_reg <= row_cnt_reg + 1'b1;
                    if (row_cnt_reg == rows_reg - 1'b1) begin
                        state_reg <= S_START;
                    end
                end
                S_START: begin
                    run_cycles_reg <= '0;
                    state_reg      <= S_RUN;
                end
                S_RUN: begin
                    run_cycles_reg <= run_cycles_reg + 32'd1;
                    if (run_take) begin
                        row_cnt_reg     <= '0;
                        pend_reg        <= 1'b0;
                        fifo_cnt_reg    <= '0;
                        fifo_wr_ptr_reg <= 1'b0;
                        fifo_rd_ptr_reg <= 1'b0;
                        state_reg       <= S_READ;
                    end
`ifdef QEA_RUN_TIMEOUT_EN
                    else if (run_cycles_reg + 32'd1 == TIMEOUT_CYCLES) begin
                        error_reg <= 1'b1;
                        state_reg <= S_DONE;
                    end
`endif
                end
                S_READ: begin
                    pend_reg      <= rd_issue;
                    pend_addr_reg <= row_cnt_reg[STATE_ADDR_WIDTH-1:0];
                    if (rd_issue) begin
                        row_cnt_reg <= row_cnt_reg + 1'b1;
                    end
                    if (pend_reg) begin
                        fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
                    end
                    if (res_pop) begin
                        fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
                    end
                    fifo_cnt_reg <= fifo_cnt_reg + {1'b0, pend_reg} - {1'b0, res_pop};
                    if (res_pop && m_res_last) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (pend_reg) begin
            fifo_data_reg[fifo_wr_ptr_reg] <= i_qea_state_dout;
            fifo_addr_reg[fifo_wr_ptr_reg] <= pend_addr_reg;
            fifo_last_reg[fifo_wr_ptr_reg] <= ({1'b0, pend_addr_reg} == rows_reg - 1'b1);
        end
    end

    assign s_ctx_ready    = (state_reg == S_LOAD_CTX);
    assign o_qea_start    = (state_reg == S_START);
    assign o_done         = (state_reg == S_DONE);
    assign o_busy         = (state_reg != S_IDLE);
    assign o_qea_qbit_num = qbit_reg;
    assign o_ctx_en       = ctx_en_reg;
    assign o_ctx_wea      = ctx_wea_reg;
    assign o_ctx_addr     = ctx_addr_reg;
    assign o_ctx_data     = ctx_data_reg;
    assign o_run_cycles   = run_cycles_reg;
    assign m_res_data     = m_res_valid ? fifo_data_reg[fifo_rd_ptr_reg] : '0;
    assign m_res_addr     = m_res_valid ? fifo_addr_reg[fifo_rd_ptr_reg] : '0;
    assign m_res_last     = m_res_valid ? fifo_last_reg[fifo_rd_ptr_reg] : 1'b0;

endmodule

// File: tb/tb_qea_host_sequencer.sv
`timescale 1ns/1ps
module tb_qea_host_sequencer;

`ifdef QEA_RUN_TIMEOUT_EN
    localparam int TO_CYC = 300;
`else
    localparam int TO_CYC = 1000000;
`endif
    localparam int BUDGET = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_go = 1'b0;
    logic [15:0]  i_ins_num = '0;
    logic [5:0]   i_qbit_num = '0;
    logic         s_ctx_valid = 1'b0;
    logic         s_ctx_ready;
    logic [63:0]  s_ctx_data = '0;
    logic         o_qea_start;
    logic [5:0]   o_qea_qbit_num;
    logic         o_ctx_en, o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic [3:0]   o_state_ena, o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic         i_qea_complete = 1'b0;
    logic [255:0] i_qea_state_dout = '0;
    logic         m_res_valid;
    logic         m_res_ready = 1'b0;
    logic [255:0] m_res_data;
    logic [15:0]  m_res_addr;
    logic         m_res_last;
    logic         o_busy, o_done, o_error;
    logic [31:0]  o_run_cycles;

    qea_host_sequencer #(.TIMEOUT_CYCLES(32'(TO_CYC))) dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_ins_num(i_ins_num), .i_qbit_num(i_qbit_num),
        .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
        .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_qea_complete(i_qea_complete),
        .i_qea_state_dout(i_qea_state_dout), .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
        .m_res_data(m_res_data), .m_res_addr(m_res_addr), .m_res_last(m_res_last),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_run_cycles(o_run_cycles)
    );

    always #5 clk = ~clk;

    // Behavioural STATE RAM holding the "computed" state vector, 1-cycle read.
    logic [255:0] ram [1024];
    always @(posedge clk) begin
        if (o_state_ena != 4'h0 && o_state_wea == 4'h0)
            i_qea_state_dout <= ram[o_state_addra[9:0]];
    end

    wire any_out = |{s_ctx_ready, o_qea_start, o_qea_qbit_num, o_ctx_en, o_ctx_wea, o_ctx_addr,
                     o_ctx_data, o_state_ena, o_state_wea, o_state_addra, o_state_dina,
                     m_res_valid, m_res_data, m_res_addr, m_res_last, o_busy, o_done,
                     o_error, o_run_cycles};

    int pass_cnt  = 0;
    int check_cnt = 0;
    int run_idx   = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One full host sequence. cdelay: cycle offset (from the start pulse) at
    // which complete rises, -1 = never. stale: complete still high from a
    // previous run during the start pulse and the two cycles after it.
    task automatic run_seq(input int qbit, input int nins, input bit gap, input int rmode,
                           input int cdelay, input bit stale, input bit mid_rst);
        int rows;
        logic [63:0] ctx_q [$];
        int sent, wr_seen, init_seen, rd_seen, starts, cyc, start_cyc, first_wr, last_wr, k;
        bit done_seen, hold_prev;
        logic [255:0] prev_data, exp_row;
        logic [15:0]  prev_addr;
        logic [63:0]  exp_ctx;
        rows = (qbit <= 2) ? 1 : (1 << (qbit - 2));
        sent = 0; wr_seen = 0; init_seen = 0; rd_seen = 0; starts = 0; cyc = 0;
        start_cyc = -1; first_wr = -1; last_wr = -1;
        done_seen = 0; hold_prev = 0; prev_data = '0; prev_addr = '0;
        for (int i = 0; i < nins; i++) ctx_q.push_back({$urandom, $urandom});

        @(negedge clk);
        i_go = 1'b1; i_qbit_num = 6'(qbit); i_ins_num = 16'(nins);
        i_qea_complete = stale; s_ctx_valid = 1'b0; m_res_ready = 1'b0;
        @(negedge clk);

        while (!done_seen && cyc < BUDGET) begin
            // ---- observe registered outputs ----
            if (mid_rst && m_res_valid) begin
                rst = 1'b1; i_go = 1'b0;
                @(negedge clk);
                check_val("rst_mid_read_all_zero", 256'(any_out), 256'd0);
                rst = 1'b0;
                $display("run %0d: qbit=%0d ins=%0d reset during readback", run_idx, qbit, nins);
                run_idx++;
                return;
            end
            if (o_ctx_en) begin
                exp_ctx = (wr_seen < nins) ? ctx_q[wr_seen] : 64'd0;
                check_val("ctx_write", {o_ctx_wea, o_ctx_addr, o_ctx_data}, {1'b1, 16'(wr_seen), exp_ctx});
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                wr_seen++;
            end
            if (o_state_wea != 4'h0) begin
                exp_row = '0;
                if (init_seen == 0) exp_row[3*64+32 +: 32] = 32'h4000_0000;
                check_val("init_ctl", {o_state_ena, o_state_wea, o_state_addra}, {4'hf, 4'hf, 16'(init_seen)});
                check_val("init_data", o_state_dina, exp_row);
                init_seen++;
            end
            if (o_qea_start) begin
                starts++;
                start_cyc = cyc;
                check_val("start_order", {16'(wr_seen), 16'(init_seen), 8'(starts), o_qea_qbit_num},
                          {16'(nins), 16'(rows), 8'd1, 6'(qbit)});
                for (int r = 0; r < rows && r < 1024; r++) ram[r] = {8{$urandom}};
            end
            if (m_res_valid && hold_prev)
                check_val("res_hold", 256'(m_res_data == prev_data && m_res_addr == prev_addr), 256'd1);
            if (o_done) begin
                done_seen = 1'b1;
                check_val("done_summary", {16'(rd_seen), o_error, o_run_cycles},
                          {(cdelay < 0) ? 16'd0 : 16'(rows), 1'(cdelay < 0),
                           (cdelay < 0) ? 32'(TO_CYC) : 32'(cdelay)});
                if (!gap && nins > 0)
                    check_val("ctx_span_cycles", 256'(last_wr - first_wr + 1), 256'(nins));
            end

            // ---- drive inputs for the coming edge ----
            i_go = 1'($urandom_range(0, 1));       // must be ignored while busy
            i_qbit_num = 6'($urandom);
            i_ins_num = 16'($urandom);
            if (sent < nins) begin
                s_ctx_valid = gap ? (cyc % 3 != 2) : 1'b1;
                s_ctx_data = ctx_q[sent];
            end else begin
                s_ctx_valid = 1'b0;
                s_ctx_data = {$urandom, $urandom};
            end
            case (rmode)
                0: m_res_ready = 1'b1;
                1: m_res_ready = cyc[0];
                default: m_res_ready = 1'($urandom_range(0, 1));
            endcase
            if (start_cyc < 0) begin
                i_qea_complete = stale;
            end else begin
                k = cyc - start_cyc;
                if (cdelay >= 0 && k >= cdelay) i_qea_complete = 1'b1;
                else i_qea_complete = stale && (k < 3);
            end

            // ---- handshakes that the coming edge will take ----
            if (s_ctx_valid && s_ctx_ready) sent++;
            if (m_res_valid && m_res_ready) begin
                exp_row = (rd_seen < rows && rd_seen < 1024) ? ram[rd_seen] : '0;
                check_val("res_addr_last", {m_res_last, m_res_addr}, {1'(rd_seen == rows - 1), 16'(rd_seen)});
                check_val("res_data", m_res_data, exp_row);
                rd_seen++;
            end
            hold_prev = m_res_valid && !m_res_ready;
            prev_data = m_res_data;
            prev_addr = m_res_addr;

            @(negedge clk);
            cyc++;
        end

        i_go = 1'b0; s_ctx_valid = 1'b0;
        if (!done_seen) check_val("run_cycle_budget", 256'd0, 256'd1);
        @(negedge clk);
        check_val("idle_after_done", {o_busy, o_done, m_res_valid, s_ctx_ready}, 4'b0);
        $display("run %0d: qbit=%0d ins=%0d rows=%0d ctx=%0d init=%0d read=%0d run_cycles=%0d err=%0b",
                 run_idx, qbit, nins, rows, wr_seen, init_seen, rd_seen, o_run_cycles, o_error);
        run_idx++;
    endtask

    initial begin
        for (int r = 0; r < 1024; r++) ram[r] = '0;
        repeat (2) @(negedge clk);
        check_val("reset_all_zero", 256'(any_out), 256'd0);
        rst = 1'b0;

        run_seq(12, 1165, 1'b0, 0, 5, 1'b0, 1'b0);   // full QFT-sized run
        run_seq(12, 1165, 1'b1, 1, 7, 1'b1, 1'b0);   // ctx gaps, ready toggling, stale complete
        run_seq(2, 0, 1'b0, 0, 3, 1'b0, 1'b0);       // no ctx, single row
        run_seq(2, 0, 1'b0, 2, 4, 1'b1, 1'b1);       // reset during readback
        for (int i = 0; i < 6; i++)
            run_seq($urandom_range(0, 8), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2), $urandom_range(3, 20), 1'($urandom_range(0, 1)), 1'b0);
`ifdef QEA_RUN_TIMEOUT_EN
        run_seq(3, 5, 1'b0, 0, -1, 1'b0, 1'b0);      // complete never arrives
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
